// File: rtl/load_pkg.sv
// Program loader shared types.
//   load_state_e : loader FSM states
//   TGT_INSTR / TGT_DATA : frame header target codes
//   is_tgt()     : 1 when a header byte names a valid target
package load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } load_state_e;

  localparam logic [7:0] TGT_INSTR = 8'h00;
  localparam logic [7:0] TGT_DATA  = 8'h01;

  function automatic logic is_tgt(input logic [7:0] b);
    return (b == TGT_INSTR) || (b == TGT_DATA);
  endfunction

endpackage

// File: rtl/prog_load_sequencer_word_assembler.sv
// word_assembler: packs four LSB-first bytes into a 32-bit word.
//   clk, rst      : clock, async active-high reset
//   clr           : sync clear of byte counter and partial word
//   byte_valid    : byte_in is valid this cycle
//   byte_in[7:0]  : incoming byte
//   word[31:0]    : assembled word, valid while word_valid is high
//   word_valid    : 1 on the cycle the 4th byte arrives (combinational)
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  // Only three bytes ever need storing; the 4th is taken straight from byte_in.
  logic [23:0] sr;

  assign word_valid = byte_valid && (cnt == 2'd3);
  assign word       = {byte_in, sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
      sr  <= {byte_in, sr[23:8]};
    end
  end

endmodule

// File: rtl/prog_load_sequencer.sv
// prog_load_sequencer: decodes a UART program frame (TGT, LEN_LO, LEN_HI,
// N x 4 bytes LSB first) into memory writes, holds the CPU until the image
// is complete, then hands the memory write port to the CPU.
//   clk, reset        : clock, async active-high reset
//   rx_valid/rx_byte  : received byte strobe and value
//   load_req          : restart loading from DONE or ERR
//   cpu_we/sel/addr/wdata : CPU write request
//   mem_we/sel/addr/wdata : arbitrated memory write port
//   cpu_hold          : CPU stalled
//   load_done         : image loaded, CPU running
//   load_err          : frame aborted
module prog_load_sequencer
  import load_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              load_req,
  input  logic              cpu_we,
  input  logic              cpu_sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam int unsigned     MAX_WORDS = 32'd1 << ADDR_W;

  load_state_e       state;
  logic              tgt;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0]     to_cnt;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;

  logic [31:0]       asm_word;
  logic              asm_valid;
  logic              active;
  logic              expire;
  logic              last_word;
  logic [15:0]       len_n;
  logic              sel_ld;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (reset),
    .clr        (state != DATA),
    .byte_valid (rx_valid && (state == DATA)),
    .byte_in    (rx_byte),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  assign active    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  // A byte arriving on the expiry cycle is consumed instead of aborting.
  assign expire    = active && !rx_valid && (to_cnt == TO_LAST);
  assign last_word = (32'(idx) + 32'd1) == 32'(len);
  assign len_n     = {rx_byte, len_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tgt       <= 1'b0;
      len_lo    <= '0;
      len       <= '0;
      idx       <= '0;
      to_cnt    <= '0;
      ld_we     <= 1'b0;
      ld_addr   <= '0;
      ld_wdata  <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      ld_we  <= 1'b0;
      // Every active-state entry coincides with a byte, so clearing on
      // rx_valid also covers the clear-on-entry rule.
      to_cnt <= (!active || rx_valid) ? '0 : to_cnt + TW'(1);

      unique case (state)
        IDLE: if (rx_valid) begin
          if (is_tgt(rx_byte)) begin
            tgt   <= rx_byte[0];
            state <= LEN_LO;
          end else begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end

        LEN_LO: if (rx_valid) begin
          len_lo <= rx_byte;
          state  <= LEN_HI;
        end else if (expire) begin
          state    <= ERR;
          load_err <= 1'b1;
        end

        LEN_HI: if (rx_valid) begin
          len <= len_n;
          if (len_n == 16'd0) begin
            state     <= DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end else if (32'(len_n) > MAX_WORDS) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            state <= DATA;
          end
        end else if (expire) begin
          state    <= ERR;
          load_err <= 1'b1;
        end

        DATA: if (asm_valid) begin
          ld_we    <= 1'b1;
          ld_addr  <= idx;
          ld_wdata <= asm_word;
          idx      <= idx + ADDR_W'(1);
          // DONE is entered together with the final write; the mux keeps
          // the loader on the port for that cycle.
          if (last_word) begin
            state     <= DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
          end
        end else if (expire) begin
          state    <= ERR;
          load_err <= 1'b1;
        end

        DONE: if (load_req) begin
          state     <= IDLE;
          cpu_hold  <= 1'b1;
          load_done <= 1'b0;
          idx       <= '0;
          len       <= '0;
          len_lo    <= '0;
        end

        ERR: if (load_req) begin
          state    <= IDLE;
          load_err <= 1'b0;
          idx      <= '0;
          len      <= '0;
          len_lo   <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign sel_ld    = (state != DONE) || ld_we;
  assign mem_we    = sel_ld ? ld_we    : cpu_we;
  assign mem_sel   = sel_ld ? tgt      : cpu_sel;
  assign mem_addr  = sel_ld ? ld_addr  : cpu_addr;
  assign mem_wdata = sel_ld ? ld_wdata : cpu_wdata;

endmodule

// File: tb/tb_prog_load_sequencer.sv
module tb_prog_load_sequencer;

  localparam int AW  = 4;
  localparam int TO  = 16;
  localparam int MW  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid, load_req, cpu_we, cpu_sel;
  logic [7:0]    rx_byte;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          mem_we, mem_sel, cpu_hold, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  always #5 clk = ~clk;

  prog_load_sequencer #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .load_req(load_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Memory as seen on the write port, and the memory image the frames imply.
  logic [31:0] dut_mem [2][MW];
  logic [31:0] exp_mem [2][MW];
  int          wr_cnt = 0;

  initial begin
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < MW; a++) begin
        dut_mem[s][a] = '0;
        exp_mem[s][a] = '0;
      end
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cnt++;
      dut_mem[mem_sel][mem_addr] = mem_wdata;
    end
  end

  logic [31:0] frame_words[$];

  task automatic fill_rand(input int n);
    frame_words.delete();
    for (int k = 0; k < n; k++) frame_words.push_back($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic cmp_mem(input string tag);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < MW; a++)
        chk($sformatf("%s_m%0d_%0d", tag, s, a), dut_mem[s][a], exp_mem[s][a]);
  endtask

  task automatic chk_status(input string tag, input logic h, input logic d, input logic e);
    chk({tag, "_hold"}, 32'(cpu_hold),  32'(h));
    chk({tag, "_done"}, 32'(load_done), 32'(d));
    chk({tag, "_err"},  32'(load_err),  32'(e));
  endtask

  // Sends a well-headed frame of n words from frame_words. abort_after >= 0
  // stalls for a full timeout after that byte index. gap_fix >= 0 forces the
  // idle gap between bytes, otherwise gaps are random 0..3.
  task automatic send_frame(input logic [7:0] tgt, input int n, input int abort_after,
                            input int gap_fix, input bit req_mid);
    logic [7:0] bq[$];
    logic [31:0] w;
    int wr0, nexp, req_at, gap, k, last;
    bq.push_back(tgt);
    bq.push_back(8'(n));
    bq.push_back(8'(n >> 8));
    for (int j = 0; j < n; j++) begin
      w = frame_words[j];
      for (int b = 0; b < 4; b++) bq.push_back(8'(w >> (8 * b)));
    end
    last   = bq.size() - 1;
    req_at = req_mid ? $urandom_range(0, last - 1) : -1;
    nexp   = (abort_after < 0) ? n : ((abort_after >= 6) ? (abort_after - 2) / 4 : 0);
    wr0    = wr_cnt;
    cpu_we = 1'b1; cpu_sel = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom;
    for (int i = 0; i <= last; i++) begin
      if (i == last && n == 0) cpu_we = 1'b0;
      send_byte(bq[i]);
      if (i >= 6 && ((i - 6) % 4) == 0) begin
        k = (i - 6) / 4;
        chk("w_we",   32'(mem_we),   32'd1);
        chk("w_sel",  32'(mem_sel),  32'(tgt[0]));
        chk("w_addr", 32'(mem_addr), 32'(k));
        chk("w_data", mem_wdata,     frame_words[k]);
        exp_mem[tgt[0]][k] = frame_words[k];
      end
      if (i == last) cpu_we = 1'b0;
      if (i == abort_after) begin
        repeat (TO - 1) @(negedge clk);
        chk("to_pre", 32'(load_err), 32'd0);
        @(negedge clk);
        break;
      end
      if (i == req_at) pulse_req();
      gap = (gap_fix >= 0) ? gap_fix : $urandom_range(0, 3);
      if (i < last) repeat (gap) @(negedge clk);
    end
    cpu_we = 1'b0;
    #1;
    chk("wr_cnt", 32'(wr_cnt - wr0), 32'(nexp));
    if (abort_after >= 0) chk_status("fr_abort", 1'b1, 1'b0, 1'b1);
    else                  chk_status("fr_ok",    1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int wr0, n, ab;
    logic [7:0] t;
    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0; load_req = 1'b0;
    cpu_we = 1'b0; cpu_sel = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk_status("rst", 1'b1, 1'b0, 1'b0);
    chk("rst_we",   32'(mem_we),   0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", mem_wdata,     0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word instruction image.
    frame_words = {32'h12345678, 32'hDEADBEEF};
    send_frame(8'h00, 2, -1, 0, 1'b0);
    cmp_mem("t1");

    // Bytes in DONE do nothing.
    wr0 = wr_cnt;
    send_byte(8'h00);
    send_byte(8'h07);
    #1;
    chk("done_rx_wr", 32'(wr_cnt - wr0), 0);
    chk_status("done_rx", 1'b0, 1'b1, 1'b0);

    // CPU owns the port in DONE.
    for (int i = 0; i < 6; i++) begin
      cpu_we = $urandom; cpu_sel = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom;
      #1;
      chk("cpu_we",   32'(mem_we),   32'(cpu_we));
      chk("cpu_sel",  32'(mem_sel),  32'(cpu_sel));
      chk("cpu_addr", 32'(mem_addr), 32'(cpu_addr));
      chk("cpu_data", mem_wdata,     cpu_wdata);
      if (cpu_we) exp_mem[cpu_sel][cpu_addr] = cpu_wdata;
      @(negedge clk);
    end
    cpu_we = 1'b0;
    cmp_mem("cpu");

    pulse_req();
    chk_status("req", 1'b1, 1'b0, 1'b0);

    // Empty data frame.
    frame_words.delete();
    send_frame(8'h01, 0, -1, 0, 1'b0);
    pulse_req();

    // Bad header, ignored bytes in ERR, recovery.
    send_byte(8'h07);
    chk_status("bad_hdr", 1'b1, 1'b0, 1'b1);
    send_byte(8'h00);
    chk_status("err_rx", 1'b1, 1'b0, 1'b1);
    pulse_req();
    chk_status("err_clr", 1'b1, 1'b0, 1'b0);
    fill_rand(3);
    send_frame(8'h01, 3, -1, -1, 1'b0);
    cmp_mem("t3");
    pulse_req();

    // Timeout mid-word, then bytes arriving exactly on the expiry cycle.
    frame_words = {32'h0000BBAA};
    send_frame(8'h00, 1, 4, 0, 1'b0);
    pulse_req();
    fill_rand(1);
    send_frame(8'h00, 1, -1, TO - 1, 1'b0);
    cmp_mem("t4");

    // Reload from DONE with CPU writes held on.
    pulse_req();
    frame_words = {32'h01020304};
    send_frame(8'h00, 1, -1, 0, 1'b0);
    cmp_mem("t5");
    pulse_req();

    // Oversize rejected, exact maximum accepted.
    wr0 = wr_cnt;
    send_byte(8'h00); send_byte(8'(MW + 1)); send_byte(8'((MW + 1) >> 8));
    #1;
    chk_status("oversz", 1'b1, 1'b0, 1'b1);
    chk("oversz_wr", 32'(wr_cnt - wr0), 0);
    pulse_req();
    fill_rand(MW);
    send_frame(8'h01, MW, -1, -1, 1'b0);
    cmp_mem("max");
    pulse_req();

    // Random frames: mixed targets, lengths, gaps, aborts, ignored load_req.
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        t = 8'($urandom_range(2, 255));
        send_byte(t);
        chk_status("rnd_hdr", 1'b1, 1'b0, 1'b1);
      end else begin
        n  = $urandom_range(1, 6);
        ab = $urandom_range(0, 1) ? int'($urandom_range(0, 4 * n + 1)) : -1;
        fill_rand(n);
        send_frame(8'($urandom_range(0, 1)), n, ab, -1, 1'($urandom_range(0, 1)));
      end
      pulse_req();
      chk_status("rnd_req", 1'b1, 1'b0, 1'b0);
    end
    cmp_mem("rnd");

    // Reset two and a half words into a three-word frame.
    fill_rand(3);
    wr0 = wr_cnt;
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    for (int j = 0; j < 10; j++) begin
      send_byte(8'(frame_words[j / 4] >> (8 * (j % 4))));
      if ((j % 4) == 3) exp_mem[0][j / 4] = frame_words[j / 4];
    end
    #2 reset = 1'b1;
    #1;
    chk_status("mid_rst", 1'b1, 1'b0, 1'b0);
    chk("mid_rst_we",   32'(mem_we),   0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_data", mem_wdata,     0);
    @(negedge clk);
    send_byte(8'(frame_words[2] >> 16));
    send_byte(8'(frame_words[2] >> 24));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_wr", 32'(wr_cnt - wr0), 2);
    chk_status("post_rst", 1'b1, 1'b0, 1'b0);
    cmp_mem("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
